// File: rtl/daq_file_reader_if.sv
// Single-transaction wishbone master front-end bundle, shared by the DAQ writer and reader.
interface daq_file_reader_if #(
    parameter int aw = 32,
    parameter int dw = 32
);
    logic [aw-1:0] address;
    logic          start;
    logic [3:0]    selection;
    logic          write;
    logic [dw-1:0] data_wr;
    logic [dw-1:0] data_rd;
    logic          active;

    modport master (
        output address, start, selection, write, data_wr,
        input  data_rd, active
    );

    modport slave (
        input  address, start, selection, write, data_wr,
        output data_rd, active
    );
endinterface

// File: rtl/daq_file_reader.sv
// DAQ circular-file reader: pops one 32-bit sample at rd_ptr and writes the descriptor back.
// Optional DAQ_READER_PEEK_EN adds file_peek, which returns the sample without writeback.

`ifndef WB_RAM0
`define WB_RAM0 32'h0001_0000
`endif
`ifndef FILE_START_OFFSET
`define FILE_START_OFFSET 32'h00
`endif
`ifndef FILE_END_OFFSET
`define FILE_END_OFFSET 32'h04
`endif
`ifndef FILE_RDPTR_OFFSET
`define FILE_RDPTR_OFFSET 32'h08
`endif
`ifndef FILE_WRPTR_OFFSET
`define FILE_WRPTR_OFFSET 32'h0C
`endif
`ifndef FILE_STATUS_OFFSET
`define FILE_STATUS_OFFSET 32'h10
`endif
`ifndef F_STATUS_WRAP_AROUND
`define F_STATUS_WRAP_AROUND 0
`endif

// state          | meaning
// IDLE           | waiting for file_read
// RD_<field>     | descriptor read request (start, end, rd_ptr, wr_ptr, status)
// RD_<field>_DONE| wait for active low, capture data_rd
// CHECK          | empty decision
// RD_DATA(_DONE) | fetch sample at rd_ptr, compute next rd_ptr/status
// WR_STATUS(_DONE)| write status back
// WR_RDPTR(_DONE)| write next rd_ptr back
// DONE           | file_done pulse
module daq_file_reader #(
    parameter int          dw          = 32,
    parameter int          aw          = 32,
    parameter logic [31:0] DESC_STRIDE = 32'h20
) (
    input  logic              wb_clk,
    input  logic              wb_rst_n,
    input  logic [7:0]        file_num,
    input  logic              file_read,
`ifdef DAQ_READER_PEEK_EN
    input  logic              file_peek,
`endif
    output logic [dw-1:0]     file_read_data,
    output logic              file_done,
    output logic              file_empty,
    output logic              file_active,
    daq_file_reader_if.master bus
);

    localparam int WRAP_BIT = `F_STATUS_WRAP_AROUND;

    typedef enum logic [4:0] {
        IDLE,
        RD_START,
        RD_START_DONE,
        RD_END,
        RD_END_DONE,
        RD_RDPTR,
        RD_RDPTR_DONE,
        RD_WRPTR,
        RD_WRPTR_DONE,
        RD_STATUS,
        RD_STATUS_DONE,
        CHECK,
        RD_DATA,
        RD_DATA_DONE,
        WR_STATUS,
        WR_STATUS_DONE,
        WR_RDPTR,
        WR_RDPTR_DONE,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [aw-1:0] base_q, base_d;
    logic [dw-1:0] start_addr_q, start_addr_d;
    logic [dw-1:0] end_addr_q, end_addr_d;
    logic [dw-1:0] rd_ptr_q, rd_ptr_d;
    logic [dw-1:0] wr_ptr_q, wr_ptr_d;
    logic [dw-1:0] status_q, status_d;
    logic [dw-1:0] data_q, data_d;
    logic          empty_q, empty_d;
    logic          peek_q, peek_d;

    logic          peek_req;
    logic [dw-1:0] next_rd;
    logic          rd_wraps;

    logic [aw-1:0] req_addr;
    logic          req_write;
    logic [dw-1:0] req_data;
    logic          req_phase;
    logic          hold_phase;

`ifdef DAQ_READER_PEEK_EN
    assign peek_req = file_peek;
`else
    assign peek_req = 1'b0;
`endif

    // Pointer compare is unsigned on the 32-bit wrapped sum.
    assign next_rd  = rd_ptr_q + dw'(4);
    assign rd_wraps = next_rd > end_addr_q;

    assign file_read_data = data_q;
    assign file_empty     = empty_q;

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            start_addr_q <= '0;
            end_addr_q   <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            status_q     <= '0;
            data_q       <= '0;
            empty_q      <= 1'b0;
            peek_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            start_addr_q <= start_addr_d;
            end_addr_q   <= end_addr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            status_q     <= status_d;
            data_q       <= data_d;
            empty_q      <= empty_d;
            peek_q       <= peek_d;
        end
    end

    // Address map per access; the _DONE half keeps the address stable.
    always_comb begin
        req_addr   = '0;
        req_write  = 1'b0;
        req_data   = '0;
        req_phase  = 1'b0;
        hold_phase = 1'b0;
        case (state_q)
            RD_START, RD_START_DONE: req_addr = base_q + aw'(`FILE_START_OFFSET);
            RD_END, RD_END_DONE:     req_addr = base_q + aw'(`FILE_END_OFFSET);
            RD_RDPTR, RD_RDPTR_DONE: req_addr = base_q + aw'(`FILE_RDPTR_OFFSET);
            RD_WRPTR, RD_WRPTR_DONE: req_addr = base_q + aw'(`FILE_WRPTR_OFFSET);
            RD_STATUS, RD_STATUS_DONE: req_addr = base_q + aw'(`FILE_STATUS_OFFSET);
            RD_DATA, RD_DATA_DONE:   req_addr = aw'(rd_ptr_q);
            WR_STATUS, WR_STATUS_DONE: begin
                req_addr  = base_q + aw'(`FILE_STATUS_OFFSET);
                req_write = 1'b1;
                req_data  = status_q;
            end
            WR_RDPTR, WR_RDPTR_DONE: begin
                req_addr  = base_q + aw'(`FILE_RDPTR_OFFSET);
                req_write = 1'b1;
                req_data  = rd_ptr_q;
            end
            default: req_addr = '0;
        endcase
        case (state_q)
            RD_START, RD_END, RD_RDPTR, RD_WRPTR, RD_STATUS,
            RD_DATA, WR_STATUS, WR_RDPTR: req_phase = 1'b1;
            RD_START_DONE, RD_END_DONE, RD_RDPTR_DONE, RD_WRPTR_DONE, RD_STATUS_DONE,
            RD_DATA_DONE, WR_STATUS_DONE, WR_RDPTR_DONE: hold_phase = 1'b1;
            default: req_phase = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        start_addr_d = start_addr_q;
        end_addr_d   = end_addr_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        status_d     = status_q;
        data_d       = data_q;
        empty_d      = empty_q;
        peek_d       = peek_q;
        file_done    = 1'b0;
        file_active  = 1'b1;

        bus.address   = '0;
        bus.start     = 1'b0;
        bus.selection = 4'h0;
        bus.write     = 1'b0;
        bus.data_wr   = '0;
        if (req_phase) begin
            bus.address   = req_addr;
            bus.start     = 1'b1;
            bus.selection = 4'hF;
            bus.write     = req_write;
            bus.data_wr   = req_data;
        end else if (hold_phase) begin
            bus.address = req_addr;
        end

        case (state_q)
            IDLE: begin
                file_active = 1'b0;
                if (file_read) begin
                    base_d  = aw'(`WB_RAM0) + aw'(DESC_STRIDE) * aw'(file_num);
                    data_d  = '0;
                    empty_d = 1'b0;
                    peek_d  = peek_req;
                    state_d = RD_START;
                end
            end
            RD_START:       if (bus.active) state_d = RD_START_DONE;
            RD_START_DONE: begin
                if (!bus.active) begin
                    start_addr_d = bus.data_rd;
                    state_d      = RD_END;
                end
            end
            RD_END:         if (bus.active) state_d = RD_END_DONE;
            RD_END_DONE: begin
                if (!bus.active) begin
                    end_addr_d = bus.data_rd;
                    state_d    = RD_RDPTR;
                end
            end
            RD_RDPTR:       if (bus.active) state_d = RD_RDPTR_DONE;
            RD_RDPTR_DONE: begin
                if (!bus.active) begin
                    rd_ptr_d = bus.data_rd;
                    state_d  = RD_WRPTR;
                end
            end
            RD_WRPTR:       if (bus.active) state_d = RD_WRPTR_DONE;
            RD_WRPTR_DONE: begin
                if (!bus.active) begin
                    wr_ptr_d = bus.data_rd;
                    state_d  = RD_STATUS;
                end
            end
            RD_STATUS:      if (bus.active) state_d = RD_STATUS_DONE;
            RD_STATUS_DONE: begin
                if (!bus.active) begin
                    status_d = bus.data_rd;
                    state_d  = CHECK;
                end
            end
            // Equal pointers with the wrap flag set mean the writer lapped us: full, not empty.
            CHECK: begin
                if ((rd_ptr_q == wr_ptr_q) && !status_q[WRAP_BIT]) begin
                    empty_d = 1'b1;
                    data_d  = '0;
                    state_d = DONE;
                end else begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA:        if (bus.active) state_d = RD_DATA_DONE;
            RD_DATA_DONE: begin
                if (!bus.active) begin
                    data_d = bus.data_rd;
                    if (peek_q) begin
                        state_d = DONE;
                    end else begin
                        rd_ptr_d = rd_wraps ? start_addr_q : next_rd;
                        if (rd_wraps) status_d[WRAP_BIT] = 1'b0;
                        state_d = WR_STATUS;
                    end
                end
            end
            WR_STATUS:      if (bus.active) state_d = WR_STATUS_DONE;
            WR_STATUS_DONE: if (!bus.active) state_d = WR_RDPTR;
            WR_RDPTR:       if (bus.active) state_d = WR_RDPTR_DONE;
            WR_RDPTR_DONE:  if (!bus.active) state_d = DONE;
            DONE: begin
                file_done   = 1'b1;
                file_active = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                file_active = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_daq_file_reader.sv
// Bench for daq_file_reader: RAM-backed bus responder with programmable waits and a pop reference model.

`ifndef WB_RAM0
`define WB_RAM0 32'h0001_0000
`endif
`ifndef FILE_START_OFFSET
`define FILE_START_OFFSET 32'h00
`endif
`ifndef FILE_END_OFFSET
`define FILE_END_OFFSET 32'h04
`endif
`ifndef FILE_RDPTR_OFFSET
`define FILE_RDPTR_OFFSET 32'h08
`endif
`ifndef FILE_WRPTR_OFFSET
`define FILE_WRPTR_OFFSET 32'h0C
`endif
`ifndef FILE_STATUS_OFFSET
`define FILE_STATUS_OFFSET 32'h10
`endif
`ifndef F_STATUS_WRAP_AROUND
`define F_STATUS_WRAP_AROUND 0
`endif

module tb_daq_file_reader;
    localparam logic [31:0] RAM0      = `WB_RAM0;
    localparam logic [31:0] STRIDE    = 32'h20;
    localparam logic [31:0] OFF_START = `FILE_START_OFFSET;
    localparam logic [31:0] OFF_END   = `FILE_END_OFFSET;
    localparam logic [31:0] OFF_RDPTR = `FILE_RDPTR_OFFSET;
    localparam logic [31:0] OFF_WRPTR = `FILE_WRPTR_OFFSET;
    localparam logic [31:0] OFF_STAT  = `FILE_STATUS_OFFSET;
    localparam int          WRAP      = `F_STATUS_WRAP_AROUND;
    localparam logic [31:0] WRAP_MASK = 32'h1 << WRAP;

    logic        wb_clk;
    logic        wb_rst_n;
    logic [7:0]  file_num;
    logic        file_read;
`ifdef DAQ_READER_PEEK_EN
    logic        file_peek;
`endif
    logic [31:0] file_read_data;
    logic        file_done;
    logic        file_empty;
    logic        file_active;

    daq_file_reader_if #(.aw(32), .dw(32)) bus ();

    daq_file_reader #(.dw(32), .aw(32), .DESC_STRIDE(32'h20)) dut (
        .wb_clk         (wb_clk),
        .wb_rst_n       (wb_rst_n),
        .file_num       (file_num),
        .file_read      (file_read),
`ifdef DAQ_READER_PEEK_EN
        .file_peek      (file_peek),
`endif
        .file_read_data (file_read_data),
        .file_done      (file_done),
        .file_empty     (file_empty),
        .file_active    (file_active),
        .bus            (bus)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    int errors = 0;
    int checks = 0;
    int last_lat = 0;

    // Responder: access is accepted when start is seen; active low for pre_w cycles
    // (rising together with start when pre_w is 0), then high for hi_w cycles.
    logic [31:0] mem [logic [31:0]];
    int   pre_w = 0;
    int   hi_w  = 1;
    int   t_acc = 0;
    logic busy  = 1'b0;
    logic act_r = 1'b0;
    logic [31:0] rd_q = 32'h0;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    int   stall_cnt = 0;
    int   sel_bad = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    assign bus.active  = act_r | (bus.start & ~busy & (pre_w == 0));
    assign bus.data_rd = rd_q;

    always @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            busy  <= 1'b0;
            act_r <= 1'b0;
            t_acc <= 0;
        end else if (!busy) begin
            if (bus.start) begin
                busy  <= 1'b1;
                t_acc <= 1;
                act_r <= (1 >= pre_w) && (1 <= pre_w + hi_w - 1);
                if (bus.write) begin
                    mem[bus.address] = bus.data_wr;
                    wr_cnt++;
                end else begin
                    rd_q <= mem_rd(bus.address);
                end
            end
        end else if (t_acc >= pre_w + hi_w) begin
            busy  <= 1'b0;
            act_r <= 1'b0;
        end else begin
            t_acc <= t_acc + 1;
            act_r <= (t_acc + 1 >= pre_w) && (t_acc + 1 <= pre_w + hi_w - 1);
        end
    end

    always @(negedge wb_clk) begin
        if (bus.start === 1'b1 && bus.selection !== 4'hF) sel_bad++;
        if (bus.start === 1'b1 && bus.active === 1'b0) stall_cnt++;
        if (file_done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] desc_base(input logic [7:0] fn);
        return RAM0 + STRIDE * {24'd0, fn};
    endfunction

    task automatic set_desc(input logic [7:0] fn, input logic [31:0] s, e, rd, wr, st);
        logic [31:0] b;
        b = desc_base(fn);
        mem[b + OFF_START] = s;
        mem[b + OFF_END]   = e;
        mem[b + OFF_RDPTR] = rd;
        mem[b + OFF_WRPTR] = wr;
        mem[b + OFF_STAT]  = st;
    endtask

    // What one request should do to the file, in terms of the circular-buffer rules.
    function automatic void ref_pop(input logic [31:0] s, e, rd, wr, st, input bit pk,
                                    output logic [31:0] data, output bit emp,
                                    output logic [31:0] nrd, nst,
                                    output int nacc, nwr);
        logic [31:0] nx;
        emp  = (rd == wr) && (st[WRAP] == 1'b0);
        data = 32'h0;
        nrd  = rd;
        nst  = st;
        nacc = 5;
        nwr  = 0;
        if (!emp) begin
            data = mem_rd(rd);
            nacc = 6;
            if (!pk) begin
                nacc = 8;
                nwr  = 2;
                nx   = rd + 32'd4;
                if (nx > e) begin
                    nrd = s;
                    nst = st & ~WRAP_MASK;
                end else begin
                    nrd = nx;
                end
            end
        end
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_active"},  32'(file_active), 32'd0);
        check({tag, "_done"},    32'(file_done), 32'd0);
        check({tag, "_empty"},   32'(file_empty), 32'd0);
        check({tag, "_data"},    file_read_data, 32'd0);
        check({tag, "_start"},   32'(bus.start), 32'd0);
        check({tag, "_write"},   32'(bus.write), 32'd0);
        check({tag, "_sel"},     32'(bus.selection), 32'd0);
        check({tag, "_addr"},    bus.address, 32'd0);
        check({tag, "_wdata"},   bus.data_wr, 32'd0);
    endtask

    task automatic run_op(input logic [7:0] fn, input bit pk, input bit pulse2, input string tag);
        logic [31:0] b, exp_data, exp_rd, exp_st;
        bit          exp_emp;
        int          nacc, nwr, cyc, d0, w0, s0;
        b = desc_base(fn);
        ref_pop(mem_rd(b + OFF_START), mem_rd(b + OFF_END), mem_rd(b + OFF_RDPTR),
                mem_rd(b + OFF_WRPTR), mem_rd(b + OFF_STAT), pk,
                exp_data, exp_emp, exp_rd, exp_st, nacc, nwr);
        d0 = done_cnt;
        w0 = wr_cnt;
        s0 = stall_cnt;
        file_num  = fn;
`ifdef DAQ_READER_PEEK_EN
        file_peek = pk;
`endif
        file_read = 1'b1;
        tick();
        file_read = 1'b0;
        cyc = 1;
        check({tag, "_active"}, 32'(file_active), 32'd1);
        while (file_done !== 1'b1 && cyc < 600) begin
            file_read = pulse2 && (cyc == 3);
            if (pulse2 && cyc == 3) check({tag, "_pulse_in_rd_end"}, bus.address, b + OFF_END);
            tick();
            cyc++;
        end
        file_read = 1'b0;
        last_lat = cyc + 1;
        check({tag, "_done_seen"}, 32'(file_done), 32'd1);
        check({tag, "_done_inactive"}, 32'(file_active), 32'd0);
        check({tag, "_latency"}, 32'(cyc + 1), 32'(3 + nacc * (pre_w + hi_w + 1)));
        check({tag, "_data"}, file_read_data, exp_data);
        check({tag, "_empty"}, 32'(file_empty), 32'(exp_emp));
        repeat (6) tick();
        check({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_data_hold"}, file_read_data, exp_data);
        check({tag, "_empty_hold"}, 32'(file_empty), 32'(exp_emp));
        check({tag, "_ram_rdptr"}, mem_rd(b + OFF_RDPTR), exp_rd);
        check({tag, "_ram_status"}, mem_rd(b + OFF_STAT), exp_st);
        check({tag, "_bus_writes"}, 32'(wr_cnt - w0), 32'(nwr));
        check({tag, "_start_held"}, 32'(stall_cnt - s0), 32'(nacc * pre_w));
    endtask

    initial begin
        logic [7:0]  fn;
        logic [31:0] s, e, rd, wr, st, b;
        int          len, cyc;
        bit          pk;

        wb_rst_n  = 1'b0;
        file_read = 1'b0;
        file_num  = 8'd0;
`ifdef DAQ_READER_PEEK_EN
        file_peek = 1'b0;
`endif
        repeat (3) tick();
        check_idle_outputs("reset");
        wb_rst_n = 1'b1;
        tick();

        // Plain pop, zero-wait bus
        set_desc(8'd2, 32'h1000, 32'h10FC, 32'h1010, 32'h1020, 32'h0);
        mem[32'h1010] = 32'hDEADBEEF;
        run_op(8'd2, 1'b0, 1'b0, "pop");
        check("pop_data_const", file_read_data, 32'hDEADBEEF);
        check("pop_rdptr_const", mem_rd(desc_base(8'd2) + OFF_RDPTR), 32'h1014);
        check("pop_lat_const", 32'(last_lat), 32'd19);

        // Wrap at end_address clears only the wrap bit
        set_desc(8'd2, 32'h1000, 32'h10FC, 32'h10FC, 32'h1008, WRAP_MASK | 32'h0000_0A50);
        mem[32'h10FC] = 32'h12345678;
        run_op(8'd2, 1'b0, 1'b0, "wrap");
        check("wrap_data_const", file_read_data, 32'h12345678);
        check("wrap_rdptr_const", mem_rd(desc_base(8'd2) + OFF_RDPTR), 32'h1000);
        check("wrap_status_const", mem_rd(desc_base(8'd2) + OFF_STAT), 32'h0000_0A50);

        // Empty, then full with identical pointers
        set_desc(8'd2, 32'h1000, 32'h10FC, 32'h1020, 32'h1020, 32'h0);
        mem[32'h1020] = 32'hCAFE0001;
        run_op(8'd2, 1'b0, 1'b0, "empty");
        check("empty_flag_const", 32'(file_empty), 32'd1);
        check("empty_lat_const", 32'(last_lat), 32'd13);
        set_desc(8'd2, 32'h1000, 32'h10FC, 32'h1020, 32'h1020, WRAP_MASK);
        run_op(8'd2, 1'b0, 1'b0, "full");
        check("full_rdptr_const", mem_rd(desc_base(8'd2) + OFF_RDPTR), 32'h1024);

        // Second request while busy is dropped
        set_desc(8'd2, 32'h1000, 32'h10FC, 32'h1010, 32'h1020, 32'h0);
        run_op(8'd2, 1'b0, 1'b1, "busy");

        // Slow bus: start must hold until active rises
        pre_w = 2;
        hi_w  = 3;
        set_desc(8'd2, 32'h1000, 32'h10FC, 32'h1010, 32'h1020, 32'h0);
        run_op(8'd2, 1'b0, 1'b0, "waits");
        pre_w = 0;
        hi_w  = 1;

        // Reset while waiting out the status write
        set_desc(8'd2, 32'h1000, 32'h10FC, 32'h1010, 32'h1020, 32'h0);
        b = desc_base(8'd2);
        file_num  = 8'd2;
        file_read = 1'b1;
        tick();
        file_read = 1'b0;
        cyc = 0;
        while (!(bus.start === 1'b1 && bus.write === 1'b1) && cyc < 200) begin
            tick();
            cyc++;
        end
        check("rst_reach_wr_status", 32'({bus.start, bus.write}), 32'd3);
        tick();
        check("rst_in_wr_status_done", bus.address, b + OFF_STAT);
        check("rst_in_wr_status_done_start", 32'(bus.start), 32'd0);
        wb_rst_n = 1'b0;
        tick();
        check_idle_outputs("midrst");
        wb_rst_n = 1'b1;
        tick();
        check("midrst_rdptr_kept", mem_rd(b + OFF_RDPTR), 32'h1010);
        run_op(8'd2, 1'b0, 1'b0, "after_rst");

`ifdef DAQ_READER_PEEK_EN
        set_desc(8'd2, 32'h1000, 32'h10FC, 32'h1010, 32'h1020, 32'h0);
        run_op(8'd2, 1'b1, 1'b0, "peek");
        check("peek_data_const", file_read_data, 32'hDEADBEEF);
        check("peek_rdptr_const", mem_rd(b + OFF_RDPTR), 32'h1010);
        check("peek_lat_const", 32'(last_lat), 32'd15);
        run_op(8'd2, 1'b0, 1'b0, "pop_after_peek");
        check("pop_after_peek_const", file_read_data, 32'hDEADBEEF);
`endif

        // Random descriptors, pointers and bus timing
        for (int i = 0; i < 24; i++) begin
            fn  = 8'($urandom_range(0, 255));
            s   = 32'h2000 + (32'($urandom_range(0, 15)) << 8);
            len = int'($urandom_range(1, 64));
            e   = s + 32'(4 * (len - 1));
            rd  = s + 32'(4 * $urandom_range(0, len - 1));
            wr  = ($urandom_range(0, 3) == 0) ? rd : s + 32'(4 * $urandom_range(0, len - 1));
            st  = $urandom;
            st[WRAP] = 1'($urandom_range(0, 1));
            mem[rd]  = $urandom;
            pk = 1'b0;
`ifdef DAQ_READER_PEEK_EN
            pk = 1'($urandom_range(0, 1));
`endif
            pre_w = int'($urandom_range(0, 2));
            hi_w  = int'($urandom_range(1, 3));
            set_desc(fn, s, e, rd, wr, st);
            run_op(fn, pk, 1'b0, "rand");
        end

        check("selection_all_lanes", 32'(sel_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
